clk_ratio_detect: RTL and testbench

//   Measures a divided clock against the fast clock it was derived from.
//   div_clk is synchronised into clk_in; its period and high time are counted in
//   clk_in cycles, and lock is reported once the ratio is stable.

---
 rtl/clk_ratio_detect_pkg.sv | 15 +
 rtl/clk_ratio_detect_edge_sync.sv | 39 +++
 rtl/clk_ratio_detect.sv | 178 +++++++++++++++++
 tb/tb_clk_ratio_detect.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_detect_pkg.sv
// Shared types and defaults for the clock ratio detector.
//   meas_state_e : measurement FSM states
//   CNT_W_DEF    : default width of the period/high-time counters
package clk_meas_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } meas_state_e;

endpackage

// File: rtl/clk_ratio_detect_edge_sync.sv
// Two-flop synchroniser plus history flop with rise/fall detection.
// Ports:
//   clk_in     : sampling clock
//   reset_n    : asynchronous active-low reset
//   i_d        : asynchronous input to sample
//   o_s        : synchronised level
//   o_rise_c   : one-cycle pulse on a synchronised 0->1 transition
//   o_fall_c   : one-cycle pulse on a synchronised 1->0 transition
module edge_sync (
  input  logic clk_in,
  input  logic reset_n,
  input  logic i_d,
  output logic o_s,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Metastability stage, resolved stage, and one cycle of history for edges
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_s      = r_sync;
  assign o_rise_c = r_sync & ~r_hist;
  assign o_fall_c = ~r_sync & r_hist;

endmodule

// File: rtl/clk_ratio_detect.sv
// Measures a divided clock against the fast clock it was derived from.
// Period (rise to rise) and high time (rise to fall) are counted in clk_in
// cycles; locked is raised after LOCK_CNT consecutive matching periods.
// Ports:
//   clk_in       : measurement clock
//   reset_n      : asynchronous active-low reset
//   div_clk      : divided clock under test (asynchronous, sampled only)
//   meas_en      : 1 = measure, 0 = return to IDLE
//   period       : last complete period in clk_in cycles
//   high_time    : last complete high time in clk_in cycles
//   period_valid : one-cycle pulse when period/high_time update
//   locked       : ratio stable for LOCK_CNT consecutive periods
//   timeout      : sticky, no edge within 2**CNT_W-1 cycles
module clk_ratio_detect
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_clk,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned     DW      = CNT_W + 1;
  localparam int unsigned     MW      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_s_unused;
  logic w_rise;
  logic w_fall;

  meas_state_e      r_state,       w_state_nxt;
  logic [CNT_W-1:0] r_cnt,         w_cnt_nxt;
  logic [CNT_W-1:0] r_high_cap,    w_high_cap_nxt;
  logic [CNT_W-1:0] r_prev,        w_prev_nxt;
  logic             r_prev_ok,     w_prev_ok_nxt;
  logic [MW-1:0]    r_match,       w_match_nxt;
  logic [CNT_W-1:0] r_period,      w_period_nxt;
  logic [CNT_W-1:0] r_high_time,   w_high_time_nxt;
  logic             r_valid,       w_valid_nxt;
  logic             r_locked,      w_locked_nxt;
  logic             r_timeout,     w_timeout_nxt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [DW-1:0]    w_diff;
  logic [DW-1:0]    w_mag;
  logic             w_same;
  logic [MW-1:0]    w_match_inc;

  edge_sync u_sync (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .i_d      (div_clk),
    .o_s      (w_s_unused),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  // Saturating cycle counter increment
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Signed difference one bit wider than the counters, then magnitude
  assign w_diff      = {1'b0, r_cnt} - {1'b0, r_prev};
  assign w_mag       = w_diff[CNT_W] ? -w_diff : w_diff;
  assign w_same      = r_prev_ok && (w_mag <= DW'(TOL));
  assign w_match_inc = r_match + MW'(1);

  // Next-state and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_high_cap_nxt  = r_high_cap;
    w_prev_nxt      = r_prev;
    w_prev_ok_nxt   = r_prev_ok;
    w_match_nxt     = r_match;
    w_period_nxt    = r_period;
    w_high_time_nxt = r_high_time;
    w_valid_nxt     = 1'b0;
    w_locked_nxt    = r_locked;
    w_timeout_nxt   = r_timeout;

    if (!meas_en) begin
      // Disable wins over any edge or timeout in the same cycle
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_match_nxt   = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
    end else if (r_state == IDLE) begin
      w_state_nxt = FIRST;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = w_cnt_inc;
      if (w_rise) begin
        w_cnt_nxt = CNT_W'(1);
        if (r_state == FIRST) begin
          // Partial first period is discarded
          w_state_nxt   = MEASURE;
          w_match_nxt   = '0;
          w_prev_ok_nxt = 1'b0;
        end else begin
          w_period_nxt    = r_cnt;
          w_high_time_nxt = r_high_cap;
          w_valid_nxt     = 1'b1;
          w_prev_nxt      = r_cnt;
          w_prev_ok_nxt   = 1'b1;
          if (r_state == MEASURE) begin
            if (w_same) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc == MW'(LOCK_CNT)) begin
                w_state_nxt  = LOCKED;
                w_locked_nxt = 1'b1;
              end
            end else begin
              w_match_nxt = '0;
            end
          end else if (!w_same) begin
            w_state_nxt  = MEASURE;
            w_match_nxt  = '0;
            w_locked_nxt = 1'b0;
          end
        end
      end else if (r_cnt == CNT_MAX) begin
        // No edge within the counter range: restart and flag
        w_state_nxt   = FIRST;
        w_cnt_nxt     = '0;
        w_locked_nxt  = 1'b0;
        w_timeout_nxt = 1'b1;
      end else if (w_fall && (r_state != FIRST)) begin
        w_high_cap_nxt = r_cnt;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_high_cap  <= '0;
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_match     <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_high_cap  <= w_high_cap_nxt;
      r_prev      <= w_prev_nxt;
      r_prev_ok   <= w_prev_ok_nxt;
      r_match     <= w_match_nxt;
      r_period    <= w_period_nxt;
      r_high_time <= w_high_time_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign period       = r_period;
  assign high_time    = r_high_time;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Bench for clk_ratio_detect: two instances (8-bit/TOL=0 and 4-bit/TOL=1)
// share one div_clk stimulus and are checked every cycle against a
// timestamp-based reference model, plus scenario spot checks.
module tb_clk_ratio_detect;

  localparam int LOCKN   = 4;
  localparam int M_IDLE  = 0;
  localparam int M_FIRST = 1;
  localparam int M_MEAS  = 2;
  localparam int M_LOCK  = 3;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       div_clk;
  logic       meas_en;
  logic [7:0] period0, high0;
  logic       valid0, locked0, timeout0;
  logic [3:0] period1, high1;
  logic       valid1, locked1, timeout1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  clk_ratio_detect #(.CNT_W(8), .LOCK_CNT(LOCKN), .TOL(0)) u_dut0 (
    .clk_in(clk_in), .reset_n(reset_n), .div_clk(div_clk), .meas_en(meas_en),
    .period(period0), .high_time(high0), .period_valid(valid0),
    .locked(locked0), .timeout(timeout0));

  clk_ratio_detect #(.CNT_W(4), .LOCK_CNT(LOCKN), .TOL(1)) u_dut1 (
    .clk_in(clk_in), .reset_n(reset_n), .div_clk(div_clk), .meas_en(meas_en),
    .period(period1), .high_time(high1), .period_valid(valid1),
    .locked(locked1), .timeout(timeout1));

  // Reference model state, one slot per instance
  int c_max[2];
  int c_tol[2];
  int m_mode[2], m_base[2], m_hcap[2], m_prev[2], m_match[2];
  int m_per[2], m_high[2];
  bit m_prev_ok[2], m_val[2], m_lock[2], m_to[2];
  int n_edge;
  bit d1, d2, d3;   // div_clk as sampled at the last three clk_in edges

  // div_clk generator
  bit gen_hold, gen_rand, alt_sel;
  int gen_hi, gen_lo, gen_lo_alt, half_left;

  int vcount  = 0;
  int lock_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_base[i] = 0; m_hcap[i] = 0; m_prev[i] = 0;
      m_match[i] = 0; m_per[i] = 0; m_high[i] = 0; m_prev_ok[i] = 1'b0;
      m_val[i] = 1'b0; m_lock[i] = 1'b0; m_to[i] = 1'b0;
    end
    d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
  endtask

  // An edge on div_clk first sampled at edge k is acted upon at edge k+2.
  // The measurement count at edge n is n - base (saturated), where base is
  // the edge at which counting (re)started.
  task automatic model_step();
    bit rise, fall, same;
    int cnt;
    n_edge++;
    rise = d2 && !d3;
    fall = !d2 && d3;
    d3 = d2; d2 = d1; d1 = div_clk;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 1'b0;
      if (!meas_en) begin
        m_mode[i] = M_IDLE; m_lock[i] = 1'b0; m_to[i] = 1'b0; m_match[i] = 0;
      end else if (m_mode[i] == M_IDLE) begin
        m_mode[i] = M_FIRST;
        m_base[i] = n_edge + 1;
      end else begin
        cnt = n_edge - m_base[i];
        if (cnt > c_max[i]) cnt = c_max[i];
        if (rise) begin
          m_base[i] = n_edge;
          if (m_mode[i] == M_FIRST) begin
            m_mode[i] = M_MEAS; m_match[i] = 0; m_prev_ok[i] = 1'b0;
          end else begin
            same = m_prev_ok[i] && (iabs(cnt - m_prev[i]) <= c_tol[i]);
            m_per[i] = cnt; m_high[i] = m_hcap[i]; m_val[i] = 1'b1;
            if (m_mode[i] == M_MEAS) begin
              if (same) begin
                m_match[i]++;
                if (m_match[i] >= LOCKN) begin m_mode[i] = M_LOCK; m_lock[i] = 1'b1; end
              end else m_match[i] = 0;
            end else if (!same) begin
              m_mode[i] = M_MEAS; m_match[i] = 0; m_lock[i] = 1'b0;
            end
            m_prev[i] = cnt; m_prev_ok[i] = 1'b1;
          end
        end else if (cnt == c_max[i]) begin
          m_to[i] = 1'b1; m_lock[i] = 1'b0; m_mode[i] = M_FIRST;
          m_base[i] = n_edge + 1;
        end else if (fall && m_mode[i] != M_FIRST) begin
          m_hcap[i] = cnt;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("u0.period",  32'(period0),  32'(m_per[0]));
    chk("u0.high",    32'(high0),    32'(m_high[0]));
    chk("u0.valid",   32'(valid0),   32'(m_val[0]));
    chk("u0.locked",  32'(locked0),  32'(m_lock[0]));
    chk("u0.timeout", 32'(timeout0), 32'(m_to[0]));
    chk("u1.period",  32'(period1),  32'(m_per[1]));
    chk("u1.high",    32'(high1),    32'(m_high[1]));
    chk("u1.valid",   32'(valid1),   32'(m_val[1]));
    chk("u1.locked",  32'(locked1),  32'(m_lock[1]));
    chk("u1.timeout", 32'(timeout1), 32'(m_to[1]));
  endtask

  // One clk_in cycle: advance the model on the edge, compare on the falling edge
  task automatic step();
    @(posedge clk_in);
    if (reset_n) model_step();
    @(negedge clk_in);
    compare_all();
    if (lock_at < 0) begin
      if (valid0) vcount++;
      if (locked0) lock_at = vcount;
    end
  endtask

  task automatic gen_tick();
    if (!gen_hold) begin
      half_left--;
      if (half_left <= 0) begin
        div_clk = ~div_clk;
        if (gen_rand) half_left = $urandom_range(1, 9);
        else if (div_clk) half_left = gen_hi;
        else begin
          half_left = alt_sel ? gen_lo_alt : gen_lo;
          alt_sel   = ~alt_sel;
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      step();
      gen_tick();
    end
  endtask

  task automatic set_div(input int hi, input int lo, input int lo_alt);
    gen_hi = hi; gen_lo = lo; gen_lo_alt = lo_alt;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit prev_div;
    c_max[0] = 255; c_max[1] = 15;
    c_tol[0] = 0;   c_tol[1] = 1;
    n_edge = 0;
    model_reset();
    gen_hold = 1'b0; gen_rand = 1'b0; alt_sel = 1'b0;
    set_div(5, 5, 5);
    half_left = $urandom_range(1, 5);
    div_clk = 1'b0;
    meas_en = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 compare_all();

    // /10 50% clock: lock on the fifth valid pulse
    @(negedge clk_in);
    reset_n = 1'b1;
    meas_en = 1'b1;
    run(120);
    chk("p1.lock_on_valid", 32'(lock_at), 32'(5));
    chk("p1.period0", 32'(period0), 32'(10));
    chk("p1.high0",   32'(high0),   32'(5));
    chk("p1.locked1", 32'(locked1), 32'(1));
    chk("p1.period1", 32'(period1), 32'(10));

    // Switch to /6 and relock
    set_div(3, 3, 3);
    run(80);
    chk("p2.locked0", 32'(locked0), 32'(1));
    chk("p2.period0", 32'(period0), 32'(6));
    chk("p2.high0",   32'(high0),   32'(3));

    // Alternating 9/10: only the TOL=1 instance locks
    set_div(5, 4, 5);
    run(120);
    chk("p3.locked1", 32'(locked1), 32'(1));
    chk("p3.locked0", 32'(locked0), 32'(0));
    set_div(7, 7, 7);
    run(30);
    chk("p3.drop1", 32'(locked1), 32'(0));

    // Hold div_clk low: 4-bit instance times out, stays sticky across relock
    set_div(5, 5, 5);
    run(100);
    chk("p4.prelock1", 32'(locked1), 32'(1));
    gen_hold = 1'b1;
    div_clk  = 1'b0;
    run(40);
    chk("p4.timeout1", 32'(timeout1), 32'(1));
    chk("p4.unlock1",  32'(locked1),  32'(0));
    chk("p4.timeout0", 32'(timeout0), 32'(0));
    gen_hold  = 1'b0;
    half_left = 5;
    run(100);
    chk("p4.sticky1", 32'(timeout1), 32'(1));
    chk("p4.relock1", 32'(locked1),  32'(1));
    meas_en = 1'b0;
    step();
    chk("p4.clear1", 32'(timeout1), 32'(0));
    meas_en = 1'b1;
    gen_tick();

    // meas_en low in the cycle a rise is acted upon
    run(100);
    chk("p5.prelock0", 32'(locked0), 32'(1));
    for (int k = 0; k < 20; k++) begin
      step();
      prev_div = div_clk;
      gen_tick();
      if (!prev_div && div_clk) break;
    end
    step();
    gen_tick();
    meas_en = 1'b0;
    step();
    chk("p5.valid0",  32'(valid0),  32'(0));
    chk("p5.valid1",  32'(valid1),  32'(0));
    chk("p5.period0", 32'(period0), 32'(10));
    chk("p5.high0",   32'(high0),   32'(5));
    chk("p5.locked0", 32'(locked0), 32'(0));
    meas_en = 1'b1;
    gen_tick();

    // Asynchronous reset in the middle of a locked period
    run(100);
    chk("p6.prelock0", 32'(locked0), 32'(1));
    @(posedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    chk("p6.rst.period0", 32'(period0), 32'(0));
    chk("p6.rst.high0",   32'(high0),   32'(0));
    chk("p6.rst.locked0", 32'(locked0), 32'(0));
    chk("p6.rst.period1", 32'(period1), 32'(0));
    chk("p6.rst.locked1", 32'(locked1), 32'(0));
    model_reset();
    run(2);
    reset_n = 1'b1;
    run(80);
    chk("p6.relock0", 32'(locked0), 32'(1));

    // Random half-periods with occasional meas_en drops
    gen_rand = 1'b1;
    repeat (1500) begin
      step();
      gen_tick();
      if (!meas_en) meas_en = ($urandom_range(0, 2) == 0);
      else          meas_en = ($urandom_range(0, 149) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
